// File: rtl/rgb_stream_out_pkg.sv
// Shared constants, FSM encoding and luma helper for the RGB plane readout
// stage that streams demosaiced pixels to a valid/ready consumer.
package rgb_stream_out_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] y;
        logic [6:0] row;
        logic [6:0] col;
        logic       last;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

    // Coefficients sum to 256, so the rounded result always fits in 8 bits.
    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b) + 16'd128;
        return acc[15:8];
    endfunction

endpackage

// File: rtl/rgb_stream_out_pix_fifo2.sv
// Two-entry FIFO holding returned pixels between the plane read port and the
// output handshake; clr empties it without touching the stored words.
module pix_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rgb_stream_out.sv
// Reads the three 128x128 colour planes in raster order and streams each pixel
// with its luma and coordinates over a valid/ready output port.
module rgb_stream_out
    import rgb_stream_out_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              wr_r,
    output logic              wr_g,
    output logic              wr_b,
    output logic [ADDR_W-1:0] addr_r,
    output logic [ADDR_W-1:0] addr_g,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [7:0]        rdata_r,
    input  logic [7:0]        rdata_g,
    input  logic [7:0]        rdata_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_r,
    output logic [7:0]        out_g,
    output logic [7:0]        out_b,
    output logic [7:0]        out_y,
    output logic [6:0]        out_row,
    output logic [6:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    // Handshake: a pixel transfers on a rising edge where out_valid && out_ready;
    // while out_valid && !out_ready the head pixel and out_valid hold unchanged.

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] flight_addr;
    logic              in_flight;
    logic              start_run;
    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        occ_eff;
    pix_t              push_pix;
    pix_t              head_pix;
    logic [PIX_W-1:0]  head_vec;

    assign start_run = start && ((state == ST_IDLE) || (state == ST_FINISH));
    assign pop       = out_valid && out_ready;

    // Occupancy counts the slot freed by this cycle's pop, which is what lets
    // a read issue every cycle while the consumer keeps up.
    assign occ_eff = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight};
    assign issue   = (state == ST_RUN) && (!fifo_full || pop) && (occ_eff < 3'd2);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RUN;
            ST_RUN:    if (issue && (rd_addr == PIX_LAST)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (pop && head_pix.last) state_nxt = ST_FINISH;
            ST_FINISH: if (start) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rd_addr     <= '0;
            flight_addr <= '0;
            in_flight   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                rd_addr   <= '0;
                in_flight <= 1'b0;
            end else begin
                in_flight <= issue;
                if (issue) begin
                    flight_addr <= rd_addr;
                    if (rd_addr != PIX_LAST) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        push_pix      = '0;
        push_pix.r    = rdata_r;
        push_pix.g    = rdata_g;
        push_pix.b    = rdata_b;
        push_pix.y    = luma(rdata_r, rdata_g, rdata_b);
        push_pix.row  = flight_addr[13:7];
        push_pix.col  = flight_addr[6:0];
        push_pix.last = (flight_addr == PIX_LAST);
    end

    pix_fifo2 #(.W(PIX_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (start_run),
        .push  (in_flight),
        .pop   (pop),
        .din   (push_pix),
        .dout  (head_vec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_pix  = pix_t'(head_vec);
    assign out_valid = !fifo_empty;
    assign out_r     = head_pix.r;
    assign out_g     = head_pix.g;
    assign out_b     = head_pix.b;
    assign out_y     = head_pix.y;
    assign out_row   = head_pix.row;
    assign out_col   = head_pix.col;
    assign out_last  = head_pix.last;

    assign wr_r      = 1'b0;
    assign wr_g      = 1'b0;
    assign wr_b      = 1'b0;
    assign addr_r    = rd_addr;
    assign addr_g    = rd_addr;
    assign addr_b    = rd_addr;
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_FINISH);
    assign state_dbg = state;

endmodule

// File: doc/rgb_stream_out.md
RGB_STREAM_OUT -- requirements
Module: rgb_stream_out

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse from the demosaic stage's done; begins readout of the 128x128 RGB planes.
REQ-004 wr_r, wr_g, wr_b  output  1 each  plane write enables; always 0 (read-only master).
REQ-005 addr_r, addr_g, addr_b  output  14 each  plane read addresses, always equal, {row[6:0], col[6:0]}.
REQ-006 rdata_r, rdata_g, rdata_b  input  8 each  plane read data, valid one cycle after the address is presented.
REQ-007 out_valid  output  1  pixel available on out_*.
REQ-008 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-009 out_r, out_g, out_b, out_y  output  8 each  pixel RGB and luma.
REQ-010 out_row, out_col  output  7 each  pixel coordinates.
REQ-011 out_last  output  1  high with pixel 16383.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  level; high in FINISH.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN, FINISH.
REQ-015 IDLE -> RUN when start=1; FINISH -> RUN when start=1; start in RUN/DRAIN SHALL be ignored.
REQ-016 Entry to RUN SHALL clear the read address counter and the FIFO and deassert done.
REQ-017 In RUN, a read SHALL issue in a cycle only if FIFO occupancy + in-flight reads < 2; each issue increments the address by 1.
REQ-018 After the read of address 16383 issues, RUN -> DRAIN with no further issues; the counter SHALL NOT wrap to 0.
REQ-019 Returned rdata SHALL be written into a 2-entry FIFO on the edge following the issue cycle, together with row, col, last and luma.
REQ-020 Luma SHALL be out_y = (77*R + 150*G + 29*B + 128) >> 8, computed with a 16-bit unsigned intermediate; the result never exceeds 255 and needs no saturation.
REQ-021 out_valid SHALL equal FIFO non-empty; out_* SHALL show the FIFO head and stay stable while out_valid && !out_ready.
REQ-022 A simultaneous FIFO push and pop SHALL keep occupancy unchanged; a push into a full FIFO cannot occur by REQ-017.
REQ-023 DRAIN -> FINISH on the edge where the out_last transfer completes.
REQ-024 Latency: with out_ready=1, the first out_valid occurs two cycles after the cycle start is sampled; throughput is then 1 pixel/cycle.
REQ-025 Pixels SHALL emit in raster order, address 0..16383, each exactly once, with no drops or duplicates under any out_ready pattern.
REQ-026 out_row and out_col SHALL equal the address bits [13:7] and [6:0] of the pixel shown.

Reset
REQ-027 When reset=0 at an edge: state=IDLE, address=0, FIFO empty, in-flight=0, wr_*=0, addr_*=0, out_valid=0, out_* data=0, out_last=0, busy=0, done=0.
REQ-028 Reset mid-operation SHALL abort immediately; no pixel is emitted until the next start.

Structure
REQ-029 A shared package SHALL hold IMG_W=128, IMG_H=128, ADDR_W=14, PIX_LAST=16383, the luma coefficients 77/150/29, and the FSM state encoding.
REQ-030 The 2-entry FIFO SHALL be a sub-module pix_fifo2, parameterised on data width, with push/pop/full/empty/count ports.

Verification
REQ-031 Reset, start pulse, out_ready=1, planes preloaded with R=addr[7:0], G=0x80, B=0xFF -> 16384 transfers, pixel 0 RGB=(0,128,255), out_y=104, out_last only on pixel 16383, done high next cycle.
REQ-032 out_ready toggles 1,0,0,1 repeating -> identical 16384-pixel sequence, at most 2 reads outstanding, out_* stable during stalls.
REQ-033 out_ready=0 for 100 cycles after start -> exactly 2 reads issued, occupancy 2, address=2; release -> pixels 0,1,2 in order.
REQ-034 Pixel (255,255,255) -> out_y=255; pixel (0,0,0) -> out_y=0.
REQ-035 reset=0 at transfer 5000, then reset=1 and start -> out_valid=0 until restart, new stream begins at row 0, col 0.
REQ-036 Second start in RUN -> ignored; start in FINISH -> done=0 next cycle and full readout repeats.
